// File: rtl/bounce_gen.sv
// bounce_gen: emulates one press/release of a mechanical push button, with LFSR-timed
// contact bounce around a stable-high hold and a stable-low settle period.
module bounce_gen #(
  parameter int unsigned BOUNCE_EDGES = 4,
  parameter logic [7:0]  BOUNCE_MAX   = 8'h0F,
  parameter logic [15:0] SETTLE_CLKS  = 16'd64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] HOLD,
  input  logic [7:0]  SEED,
  output logic        BTN,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_BOUNCE,
    ST_HOLD,
    ST_RELEASE_BOUNCE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  localparam logic [7:0] EDGES     = 8'(BOUNCE_EDGES);
  localparam bit         NO_BOUNCE = (BOUNCE_EDGES == 0);

  state_t      state_q;
  logic        btn_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  lfsr_q;
  logic [15:0] hold_q;
  logic [8:0]  segCnt_q;
  logic [15:0] phaseCnt_q;
  logic [7:0]  edgeCnt_q;

  logic [7:0]  seed_d;
  logic [15:0] hold_d;

  function automatic logic [7:0] lfsrStep(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [8:0] segLen(input logic [7:0] v);
    return {1'b0, v & BOUNCE_MAX} + 9'd1;
  endfunction

  // A zero seed would lock the LFSR and a zero hold would underflow the counter.
  assign seed_d = (SEED == 8'h00) ? 8'h01 : SEED;
  assign hold_d = (HOLD == 16'd0) ? 16'd1 : HOLD;

  // Every timed phase loads its length and ends when its down-counter reads 1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      btn_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lfsr_q     <= 8'h01;
      hold_q     <= 16'd0;
      segCnt_q   <= 9'd0;
      phaseCnt_q <= 16'd0;
      edgeCnt_q  <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          btn_q  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (START) begin
            hold_q <= hold_d;
            busy_q <= 1'b1;
            btn_q  <= 1'b1;
            if (NO_BOUNCE) begin
              state_q    <= ST_HOLD;
              lfsr_q     <= seed_d;
              phaseCnt_q <= hold_d;
            end else begin
              state_q   <= ST_PRESS_BOUNCE;
              lfsr_q    <= lfsrStep(seed_d);
              segCnt_q  <= segLen(seed_d);
              edgeCnt_q <= 8'd1;
            end
          end
        end

        ST_PRESS_BOUNCE: begin
          if (segCnt_q == 9'd1) begin
            if (edgeCnt_q == EDGES) begin
              state_q    <= ST_HOLD;
              btn_q      <= 1'b1;
              phaseCnt_q <= hold_q;
            end else begin
              edgeCnt_q <= edgeCnt_q + 8'd1;
              btn_q     <= ~btn_q;
              segCnt_q  <= segLen(lfsr_q);
              lfsr_q    <= lfsrStep(lfsr_q);
            end
          end else begin
            segCnt_q <= segCnt_q - 9'd1;
          end
        end

        ST_HOLD: begin
          if (phaseCnt_q == 16'd1) begin
            btn_q <= 1'b0;
            if (NO_BOUNCE) begin
              state_q    <= ST_SETTLE;
              phaseCnt_q <= SETTLE_CLKS;
            end else begin
              state_q   <= ST_RELEASE_BOUNCE;
              segCnt_q  <= segLen(lfsr_q);
              lfsr_q    <= lfsrStep(lfsr_q);
              edgeCnt_q <= 8'd1;
            end
          end else begin
            phaseCnt_q <= phaseCnt_q - 16'd1;
          end
        end

        ST_RELEASE_BOUNCE: begin
          if (segCnt_q == 9'd1) begin
            if (edgeCnt_q == EDGES) begin
              state_q    <= ST_SETTLE;
              btn_q      <= 1'b0;
              phaseCnt_q <= SETTLE_CLKS;
            end else begin
              edgeCnt_q <= edgeCnt_q + 8'd1;
              btn_q     <= ~btn_q;
              segCnt_q  <= segLen(lfsr_q);
              lfsr_q    <= lfsrStep(lfsr_q);
            end
          end else begin
            segCnt_q <= segCnt_q - 9'd1;
          end
        end

        ST_SETTLE: begin
          btn_q <= 1'b0;
          if (phaseCnt_q == 16'd1) begin
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            phaseCnt_q <= 16'd0;
          end else begin
            phaseCnt_q <= phaseCnt_q - 16'd1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          btn_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          btn_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BTN  = btn_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: directed checks of bounce_gen across four parameter sets sharing one
// stimulus bus; each scenario inspects only the instance it targets.
module tb_bounce_gen;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [15:0] HOLD;
  logic [7:0]  SEED;
  logic [3:0]  btnV;
  logic [3:0]  busyV;
  logic [3:0]  doneV;

  int testsRun    = 0;
  int testsFailed = 0;

  bit btnQ[$];
  bit busyQ[$];
  bit modelQ[$];
  bit prevQ[$];

  // Free-running 10 ns clock; inputs change and outputs are sampled on the falling edge.
  always #5 CLK = ~CLK;

  // Instance 0: no bounce; 1: zero-length mask; 2: defaults; 3: full 8-bit mask.
  bounce_gen #(.BOUNCE_EDGES(0), .BOUNCE_MAX(8'h0F), .SETTLE_CLKS(16'd64)) dutA (
    .CLK(CLK), .RST(RST), .START(START), .HOLD(HOLD), .SEED(SEED),
    .BTN(btnV[0]), .BUSY(busyV[0]), .DONE(doneV[0]));
  bounce_gen #(.BOUNCE_EDGES(4), .BOUNCE_MAX(8'h00), .SETTLE_CLKS(16'd64)) dutB (
    .CLK(CLK), .RST(RST), .START(START), .HOLD(HOLD), .SEED(SEED),
    .BTN(btnV[1]), .BUSY(busyV[1]), .DONE(doneV[1]));
  bounce_gen dutC (
    .CLK(CLK), .RST(RST), .START(START), .HOLD(HOLD), .SEED(SEED),
    .BTN(btnV[2]), .BUSY(busyV[2]), .DONE(doneV[2]));
  bounce_gen #(.BOUNCE_EDGES(4), .BOUNCE_MAX(8'hFF), .SETTLE_CLKS(16'd64)) dutF (
    .CLK(CLK), .RST(RST), .START(START), .HOLD(HOLD), .SEED(SEED),
    .BTN(btnV[3]), .BUSY(busyV[3]), .DONE(doneV[3]));

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Holds reset for two edges and returns on a falling edge with RST already low.
  task automatic resetAll();
    @(negedge CLK);
    RST   = 1'b1;
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Called on the falling edge of cycle 0: raises START there, then records BTN/BUSY of
  // instance sel for cycles 1.. until DONE is seen (that cycle is recorded too) or the budget ends.
  task automatic applyStimulus(input logic [15:0] h, input logic [7:0] s, input int sel,
                               input int maxCyc, input int pulseAt, input bit keepStart,
                               output int doneCyc);
    HOLD  = h;
    SEED  = s;
    START = 1'b1;
    btnQ.delete();
    busyQ.delete();
    doneCyc = 0;
    for (int n = 1; n <= maxCyc; n++) begin
      @(negedge CLK);
      btnQ.push_back(btnV[sel]);
      busyQ.push_back(busyV[sel]);
      START = keepStart || (n == pulseAt);
      if (doneV[sel]) begin
        doneCyc = n;
        break;
      end
    end
  endtask

  // Reference waveform: segment lengths from an independent LFSR model, seed used as given.
  task automatic buildModel(input logic [7:0] seed, input int hold, input int edges,
                            input logic [7:0] mask, input int settle);
    logic [7:0] l;
    int len;
    modelQ.delete();
    l = seed;
    for (int e = 0; e < edges; e++) begin
      len = int'(l & mask) + 1;
      repeat (len) modelQ.push_back(e % 2 == 0);
      l = {l[6:0], ^(l & 8'hB8)};
    end
    repeat (hold) modelQ.push_back(1'b1);
    for (int e = 0; e < edges; e++) begin
      len = int'(l & mask) + 1;
      repeat (len) modelQ.push_back(e % 2 == 1);
      l = {l[6:0], ^(l & 8'hB8)};
    end
    repeat (settle) modelQ.push_back(1'b0);
  endtask

  // Compares a captured run against modelQ: DONE cycle, BTN per cycle (first bad cycle, 0 = none),
  // BTN low in the DONE cycle and BUSY high throughout.
  task automatic checkTrace(input string tag, input int doneCyc, input int expDone);
    int firstBad;
    int firstIdle;
    firstBad  = 0;
    firstIdle = 0;
    checkOutput({tag, ".doneCycle"}, doneCyc, expDone);
    for (int i = 0; i < modelQ.size(); i++) begin
      if (i >= btnQ.size() || btnQ[i] !== modelQ[i]) begin
        firstBad = i + 1;
        break;
      end
    end
    checkOutput({tag, ".btnFirstBadCycle"}, firstBad, 0);
    for (int i = 0; i < busyQ.size(); i++) begin
      if (busyQ[i] !== 1'b1) begin
        firstIdle = i + 1;
        break;
      end
    end
    checkOutput({tag, ".busyFirstLowCycle"}, firstIdle, 0);
    if (btnQ.size() > 0) checkOutput({tag, ".btnInDone"}, btnQ[btnQ.size() - 1], 0);
  endtask

  // Main directed sequence.
  initial begin
    int d;
    int ones;
    int firstBad;
    bit anyBusy;
    bit anyDone;
    logic [12:0] patB;

    RST   = 1'b1;
    START = 1'b0;
    HOLD  = 16'd0;
    SEED  = 8'h00;

    resetAll();
    checkOutput("reset.btn",  btnV,  4'h0);
    checkOutput("reset.busy", busyV, 4'h0);
    checkOutput("reset.done", doneV, 4'h0);

    // No bounce: 10 high, 64 low, DONE in cycle 75.
    applyStimulus(16'd10, 8'h5A, 0, 200, 0, 1'b0, d);
    modelQ.delete();
    repeat (10) modelQ.push_back(1'b1);
    repeat (64) modelQ.push_back(1'b0);
    checkTrace("A", d, 75);
    @(negedge CLK);
    checkOutput("A.idleAfterDone", {btnV[0], busyV[0], doneV[0]}, 3'b000);

    // Unit-length segments: 1010, 1x5, 0101, 0x64, DONE in cycle 78.
    patB = 13'b1010_11111_0101;
    resetAll();
    applyStimulus(16'd5, 8'h33, 1, 200, 0, 1'b0, d);
    modelQ.delete();
    for (int i = 12; i >= 0; i--) modelQ.push_back(patB[i]);
    repeat (64) modelQ.push_back(1'b0);
    checkTrace("B", d, 78);

    // START pulsed mid-HOLD must neither disturb nor queue a sequence.
    resetAll();
    applyStimulus(16'd5, 8'h33, 1, 200, 6, 1'b0, d);
    checkTrace("D.pulse", d, 78);
    anyBusy = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      anyBusy |= busyV[1];
    end
    checkOutput("D.pulse.noQueue", anyBusy, 0);

    // START held high: one IDLE cycle after DONE, then BTN high again.
    resetAll();
    applyStimulus(16'd5, 8'h33, 1, 200, 0, 1'b1, d);
    checkTrace("D.held", d, 78);
    @(negedge CLK);
    checkOutput("D.held.idleCycle", {btnV[1], busyV[1]}, 2'b00);
    @(negedge CLK);
    checkOutput("D.held.restart", {btnV[1], busyV[1]}, 2'b11);
    START = 1'b0;

    // Reset during RELEASE_BOUNCE (cycle 11), then restart straight away.
    resetAll();
    HOLD    = 16'd5;
    SEED    = 8'h33;
    START   = 1'b1;
    anyDone = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      @(negedge CLK);
      START = 1'b0;
      anyDone |= doneV[1];
    end
    checkOutput("E.inRelease.btn", btnV[1], 1);
    RST = 1'b1;
    @(negedge CLK);
    anyDone |= doneV[1];
    checkOutput("E.afterRst", {btnV[1], busyV[1], anyDone}, 3'b000);
    RST = 1'b0;
    applyStimulus(16'd5, 8'h33, 1, 200, 0, 1'b0, d);
    checkTrace("E.restart", d, 78);

    // SEED 00 behaves exactly as SEED 01 under default parameters.
    resetAll();
    applyStimulus(16'd20, 8'h00, 2, 600, 0, 1'b0, d);
    buildModel(8'h01, 20, 4, 8'h0F, 64);
    checkTrace("C.seed00", d, modelQ.size() + 1);
    prevQ = btnQ;
    resetAll();
    applyStimulus(16'd20, 8'h01, 2, 600, 0, 1'b0, d);
    checkTrace("C.seed01", d, modelQ.size() + 1);
    firstBad = 0;
    if (prevQ.size() != btnQ.size()) firstBad = -1;
    else
      for (int i = 0; i < btnQ.size(); i++)
        if (prevQ[i] !== btnQ[i]) begin
          firstBad = i + 1;
          break;
        end
    checkOutput("C.runsIdentical", firstBad, 0);

    // Full mask, seed FF: first press segment is 256 clocks long.
    resetAll();
    applyStimulus(16'd3, 8'hFF, 3, 5000, 0, 1'b0, d);
    buildModel(8'hFF, 3, 4, 8'hFF, 64);
    checkTrace("F", d, modelQ.size() + 1);
    ones = 0;
    while (ones < btnQ.size() && btnQ[ones] == 1'b1) ones++;
    checkOutput("F.firstSegLen", ones, 256);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
